// File: rtl/eth_txhdrgen.sv
// Ethernet transmit header generator: streams DA, SA and optional
// Length/Type as nibbles, low nibble of each byte first.
module eth_txhdrgen #(
    parameter bit HDR_LT_EN = 1'b1
) (
    input  logic        MTxClk,
    input  logic        Reset,
    input  logic        TxHdrStart,
    input  logic [47:0] TxDA,
    input  logic [47:0] TxSA,
    input  logic [15:0] TxLenType,
    input  logic [47:0] MAC,
    input  logic        r_TxSAIns,
    input  logic        TxNibRdy,
    input  logic        TxAbort,
    output logic [3:0]  TxHdrNib,
    output logic        TxHdrNibValid,
    output logic        TxHdrLastNib,
    output logic        TxHdrBusy,
    output logic        TxHdrDone,
    output logic        TxHdrAborted,
    output logic        TxDaBroadcast,
    output logic        TxDaMulticast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DA,
        S_SA,
        S_LT,
        S_FIN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [47:0] da_q, sa_q;
    logic [15:0] lt_q;
    logic        bcast_q, mcast_q, abort_q;

    logic        accept, in_field, xfer, fld_end;
    logic [47:0] fld, fld_sh;
    logic [7:0]  byte_sel;

    assign accept   = (state_q == S_IDLE) && TxHdrStart && !TxAbort;
    assign in_field = (state_q == S_DA) || (state_q == S_SA)
                   || (state_q == S_LT);
    assign xfer     = in_field && TxNibRdy;
    assign fld_end  = (state_q == S_LT) ? (cnt_q == 4'd3)
                                        : (cnt_q == 4'd11);

    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DA;
                    cnt_d   = 4'd0;
                end
            end
            S_DA, S_SA, S_LT: begin
                if (TxAbort) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (xfer) begin
                    if (fld_end) begin
                        cnt_d = 4'd0;
                        if (state_q == S_DA)
                            state_d = S_SA;
                        else if (state_q == S_SA && HDR_LT_EN)
                            state_d = S_LT;
                        else
                            state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Field is shifted so the current byte sits at [47:40].
    always_comb begin
        fld = '0;
        unique case (1'b1)
            (state_q == S_DA): fld = da_q;
            (state_q == S_SA): fld = sa_q;
            (state_q == S_LT): fld = {lt_q, 32'h0};
            default:           fld = '0;
        endcase
        fld_sh   = fld << {cnt_q[3:1], 3'b000};
        byte_sel = fld_sh[47:40];
    end

    always_comb begin
        TxHdrNibValid = in_field;
        TxHdrNib      = 4'h0;
        if (in_field)
            TxHdrNib = cnt_q[0] ? byte_sel[7:4] : byte_sel[3:0];
        TxHdrLastNib  = in_field && fld_end
                     && ((state_q == S_LT)
                      || (state_q == S_SA && !HDR_LT_EN));
        TxHdrBusy     = (state_q != S_IDLE);
        TxHdrDone     = (state_q == S_FIN) && !TxAbort;
        TxHdrAborted  = abort_q;
        TxDaBroadcast = bcast_q;
        TxDaMulticast = mcast_q;
    end

    always_ff @(posedge MTxClk or posedge Reset) begin
        if (Reset) begin
            da_q    <= '0;
            sa_q    <= '0;
            lt_q    <= '0;
            bcast_q <= 1'b0;
            mcast_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= TxAbort && (state_q != S_IDLE);
            if (accept) begin
                da_q    <= TxDA;
                sa_q    <= r_TxSAIns ? MAC : TxSA;
                lt_q    <= TxLenType;
                bcast_q <= (TxDA == 48'hFFFF_FFFF_FFFF);
                mcast_q <= TxDA[40];
            end
        end
    end

endmodule

// File: tb/tb_eth_txhdrgen.sv
// Bench for eth_txhdrgen: table vectors, corner sequences and
// randomized headers checked against a byte-level reference model.
module tb_eth_txhdrgen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2, sains, rdy, abort;
    logic [47:0] da, sa, mac;
    logic [15:0] lt;

    logic [3:0] o1_nib, o2_nib;
    logic o1_valid, o1_last, o1_busy, o1_done, o1_abt, o1_bc, o1_mc;
    logic o2_valid, o2_last, o2_busy, o2_done, o2_abt, o2_bc, o2_mc;

    logic       sel;
    logic [3:0] m_nib;
    logic m_valid, m_last, m_busy, m_done, m_abt, m_bc, m_mc;

    always #5 clk = ~clk;

    eth_txhdrgen #(.HDR_LT_EN(1'b1)) dut1 (
        .MTxClk(clk), .Reset(rst), .TxHdrStart(start1),
        .TxDA(da), .TxSA(sa), .TxLenType(lt), .MAC(mac),
        .r_TxSAIns(sains), .TxNibRdy(rdy), .TxAbort(abort),
        .TxHdrNib(o1_nib), .TxHdrNibValid(o1_valid),
        .TxHdrLastNib(o1_last), .TxHdrBusy(o1_busy),
        .TxHdrDone(o1_done), .TxHdrAborted(o1_abt),
        .TxDaBroadcast(o1_bc), .TxDaMulticast(o1_mc)
    );

    eth_txhdrgen #(.HDR_LT_EN(1'b0)) dut2 (
        .MTxClk(clk), .Reset(rst), .TxHdrStart(start2),
        .TxDA(da), .TxSA(sa), .TxLenType(lt), .MAC(mac),
        .r_TxSAIns(sains), .TxNibRdy(rdy), .TxAbort(abort),
        .TxHdrNib(o2_nib), .TxHdrNibValid(o2_valid),
        .TxHdrLastNib(o2_last), .TxHdrBusy(o2_busy),
        .TxHdrDone(o2_done), .TxHdrAborted(o2_abt),
        .TxDaBroadcast(o2_bc), .TxDaMulticast(o2_mc)
    );

    assign m_nib   = sel ? o2_nib   : o1_nib;
    assign m_valid = sel ? o2_valid : o1_valid;
    assign m_last  = sel ? o2_last  : o1_last;
    assign m_busy  = sel ? o2_busy  : o1_busy;
    assign m_done  = sel ? o2_done  : o1_done;
    assign m_abt   = sel ? o2_abt   : o1_abt;
    assign m_bc    = sel ? o2_bc    : o1_bc;
    assign m_mc    = sel ? o2_mc    : o1_mc;

    typedef struct {
        logic [47:0]  da, sa, mac;
        logic [15:0]  lt;
        logic         sains;
        logic [111:0] nibs;
        logic         bc, mc;
    } vec_t;

    vec_t tbl[4];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [3:0] got[$];
    logic [3:0] expq[$];
    int last_idx, last_cnt, last_cyc, done_cyc, done_cnt;
    int abort_seen, hold_err;
    logic busy_after;

    task automatic check(input string name, input logic [111:0] act,
                         input logic [111:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [21:0] all_outs();
        return {o1_nib, o1_valid, o1_last, o1_busy, o1_done, o1_abt,
                o1_bc, o1_mc, o2_nib, o2_valid, o2_last, o2_busy,
                o2_done, o2_abt, o2_bc, o2_mc};
    endfunction

    // Reference: bytes go out MSB first, low nibble before high nibble.
    task automatic model(input logic [47:0] d, input logic [47:0] s,
                         input logic [15:0] l, input bit lten);
        logic [7:0] bt;
        expq.delete();
        for (int b = 0; b < 6; b++) begin
            bt = 8'((d >> (8 * (5 - b))) & 48'hFF);
            expq.push_back(bt[3:0]);
            expq.push_back(bt[7:4]);
        end
        for (int b = 0; b < 6; b++) begin
            bt = 8'((s >> (8 * (5 - b))) & 48'hFF);
            expq.push_back(bt[3:0]);
            expq.push_back(bt[7:4]);
        end
        if (lten) begin
            for (int b = 0; b < 2; b++) begin
                bt = 8'((l >> (8 * (1 - b))) & 16'hFF);
                expq.push_back(bt[3:0]);
                expq.push_back(bt[7:4]);
            end
        end
    endtask

    task automatic load_vec(input int i);
        da    = tbl[i].da;
        sa    = tbl[i].sa;
        mac   = tbl[i].mac;
        lt    = tbl[i].lt;
        sains = tbl[i].sains;
        expq.delete();
        for (int j = 0; j < 28; j++)
            expq.push_back(tbl[i].nibs[111 - 4 * j -: 4]);
    endtask

    // Cycle 1 is the cycle whose closing edge accepts the start.
    task automatic run_hdr(input bit use2, input int rmode,
                           input bit scramble);
        logic [3:0] pn;
        logic pv, pr;
        got.delete();
        last_idx = -1; last_cnt = 0; last_cyc = -1;
        done_cyc = -1; done_cnt = 0; abort_seen = 0; hold_err = 0;
        busy_after = 1'b1;
        sel = use2;
        if (use2) start2 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        pv = 1'b0; pr = 1'b1; pn = 4'h0;
        for (int c = 2; c < 400; c++) begin
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = ((c - 2) % 4 == 0) || ((c - 2) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (scramble) begin
                da    = 48'({$urandom(), $urandom()});
                sa    = 48'({$urandom(), $urandom()});
                mac   = 48'({$urandom(), $urandom()});
                lt    = 16'($urandom());
                sains = 1'($urandom());
            end
            @(negedge clk);
            if (pv && !pr && (!m_valid || m_nib !== pn)) hold_err++;
            if (m_valid && rdy) begin
                got.push_back(m_nib);
                if (m_last) begin
                    last_cnt++;
                    last_idx = got.size() - 1;
                    last_cyc = c;
                end
            end
            if (m_abt) abort_seen++;
            if (m_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c == done_cyc + 1) busy_after = m_busy;
            pv = m_valid; pr = rdy; pn = m_nib;
            @(posedge clk); #1;
            if (done_cyc > 0 && c >= done_cyc + 1) break;
        end
        rdy = 1'b1;
    endtask

    task automatic verify(input string tag, input logic bc,
                          input logic mc);
        int mm;
        mm = 0;
        for (int j = 0; j < got.size(); j++)
            if (j >= expq.size() || got[j] !== expq[j]) mm++;
        check({tag, "_len"}, got.size(), expq.size());
        check({tag, "_nibs"}, mm, 0);
        check({tag, "_lastidx"}, last_idx, expq.size() - 1);
        check({tag, "_lastcnt"}, last_cnt, 1);
        check({tag, "_donecyc"}, done_cyc, last_cyc + 1);
        check({tag, "_donecnt"}, done_cnt, 1);
        check({tag, "_noabort"}, abort_seen, 0);
        check({tag, "_idle"}, busy_after, 1'b0);
        check({tag, "_flags"}, {m_bc, m_mc}, {bc, mc});
    endtask

    initial begin
        int acc;
        logic [47:0] rda, rsa, rmac;
        logic [15:0] rlt;
        logic rsi;
        bit u2;

        tbl[0] = '{48'h0011_2233_4455, 48'h1234_5678_9ABC,
                   48'h0A0B_0C0D_0E0F, 16'h0800, 1'b1,
                   112'h001122334455A0B0C0D0E0F08000, 1'b0, 1'b0};
        tbl[1] = '{48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566,
                   48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b0,
                   112'hFFFFFFFFFFFF112233445566885B, 1'b1, 1'b1};
        tbl[2] = '{48'h0100_5E00_0001, 48'hDEAD_BEEF_0000,
                   48'h0A0B_0C0D_0E0F, 16'h86DD, 1'b1,
                   112'h1000E5000010A0B0C0D0E0F068DD, 1'b0, 1'b1};
        tbl[3] = '{48'h02AB_CDEF_0123, 48'h1122_3344_5566,
                   48'h0A0B_0C0D_0E0F, 16'h9100, 1'b0,
                   112'h20BADCFE10321122334455661900, 1'b0, 1'b0};

        rst = 1'b1; start1 = 0; start2 = 0; abort = 0; rdy = 1;
        da = '0; sa = '0; mac = '0; lt = '0; sains = 0; sel = 0;
        #3;
        check("reset_outs", all_outs(), 22'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_hdr(1'b0, 0, 1'b0);
            verify($sformatf("tbl%0d", i), tbl[i].bc, tbl[i].mc);
            if (i == 0) check("tbl0_done30", done_cyc, 30);
        end

        load_vec(0);
        run_hdr(1'b0, 1, 1'b0);
        verify("rdytog", 1'b0, 1'b0);
        check("rdytog_hold", hold_err, 0);

        // Abort while SA nibble 5 is on the bus (cycle 19).
        load_vec(0);
        sel = 1'b0;
        acc = 0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 2; c < 19; c++) begin
            @(negedge clk);
            if (o1_done) acc++;
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(negedge clk);
        check("abt_pre", {o1_busy, o1_valid, o1_nib, o1_done},
              {1'b1, 1'b1, 4'h0, 1'b0});
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abt_post", {o1_busy, o1_valid, o1_abt, o1_done},
              4'b0010);
        if (o1_done) acc++;
        @(posedge clk); #1;
        @(negedge clk);
        check("abt_pulse1", {o1_abt, o1_busy}, 2'b00);
        if (o1_done) acc++;
        check("abt_nodone", acc, 0);
        @(posedge clk); #1;
        load_vec(0);
        run_hdr(1'b0, 0, 1'b0);
        verify("after_abt", 1'b0, 1'b0);

        da = 48'h0011_2233_4455; sa = 48'h1122_3344_5566;
        mac = 48'h0A0B_0C0D_0E0F; lt = 16'h0800; sains = 1'b0;
        model(da, sa, lt, 1'b0);
        run_hdr(1'b1, 0, 1'b0);
        verify("nolt", 1'b0, 1'b0);
        check("nolt_lastval", got.size() == 24 ? got[23] : 4'hX, 4'h6);

        // Reset in the middle of DA nibble 3.
        load_vec(0);
        sel = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_pre", {o1_valid, o1_nib}, {1'b1, 4'h1});
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outs", all_outs(), 22'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        acc = 0;
        repeat (5) begin
            @(negedge clk);
            if (o1_valid || o1_busy || o1_done || o1_abt) acc++;
            @(posedge clk); #1;
        end
        check("rst_quiet", acc, 0);

        start1 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; abort = 1'b0;
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            if (o1_valid || o1_busy || o1_done || o1_abt) acc++;
            @(posedge clk); #1;
        end
        check("start_abort_idle", acc, 0);

        for (int n = 0; n < 40; n++) begin
            rda  = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) rda = 48'hFFFF_FFFF_FFFF;
            rsa  = 48'({$urandom(), $urandom()});
            rmac = 48'({$urandom(), $urandom()});
            rlt  = 16'($urandom());
            rsi  = 1'($urandom());
            u2   = ($urandom_range(0, 2) == 0);
            da = rda; sa = rsa; mac = rmac; lt = rlt; sains = rsi;
            model(rda, rsi ? rmac : rsa, rlt, !u2);
            run_hdr(u2, 2, 1'b1);
            verify($sformatf("rnd%0d", n),
                   rda == 48'hFFFF_FFFF_FFFF, rda[40]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
